// File: rtl/load_store_unit.sv
// Load/store unit: accepts one MEM-stage request per handshake and issues word-aligned accesses
// to a combinational-read memory. Sub-word loads are extended; sub-word stores use read-modify-write.
module load_store_unit #(
   parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
   parameter int unsigned MEM_SIZE  = 1048576
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_w_enable,
   input  logic [31:0] mem_data_out
);

   localparam logic [31:0] LAST_WORD = BASE_ADDR + 32'(MEM_SIZE) - 32'd4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_RMW_RD = 3'd2;
   localparam logic [2:0] S_WRITE  = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [2:0]  state, state_nxt;
   logic [2:0]  lat_f3, lat_f3_nxt;
   logic [1:0]  lat_off, lat_off_nxt;
   logic [31:0] lat_wdata, lat_wdata_nxt;

   logic        req_ready_nxt;
   logic        rsp_valid_nxt;
   logic        rsp_err_nxt;
   logic [31:0] rsp_rdata_nxt;
   logic [31:0] mem_address_nxt;
   logic [31:0] mem_data_in_nxt;
   logic        mem_w_enable_nxt;

   logic [31:0] word_addr_c;
   logic        range_err_c;
   logic        align_err_c;
   logic        f3_err_c;
   logic        req_err_c;

   // Pick the addressed lane out of a memory word and sign/zero-extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_BU:   r = {24'h0, b};
         F3_HU:   r = {16'h0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Overlay the low byte/half of the store data onto the word read back from memory.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off, input logic [31:0] wdata);
      logic [31:0] r;
      r = word;
      if (f3 == F3_B) begin
         r[{off, 3'b000} +: 8] = wdata[7:0];
      end else if (f3 == F3_H) begin
         if (off[1]) r[31:16] = wdata[15:0];
         else        r[15:0]  = wdata[15:0];
      end else begin
         r = wdata;
      end
      return r;
   endfunction

   // Request legality, evaluated against the live request fields at acceptance.
   always_comb begin
      word_addr_c = {req_addr[31:2], 2'b00};
      range_err_c = (word_addr_c < BASE_ADDR) || (word_addr_c > LAST_WORD);
      align_err_c = 1'b0;
      f3_err_c    = 1'b0;
      case (req_funct3)
         F3_B:    f3_err_c = 1'b0;
         F3_H:    align_err_c = req_addr[0];
         F3_W:    align_err_c = |req_addr[1:0];
         F3_BU:   f3_err_c = req_we;
         F3_HU: begin
            align_err_c = req_addr[0];
            f3_err_c    = req_we;
         end
         default: f3_err_c = 1'b1;
      endcase
      req_err_c = range_err_c | align_err_c | f3_err_c;
   end

   // Next-state and next-output logic; every output is the registered copy of its _nxt.
   always_comb begin
      state_nxt        = state;
      lat_f3_nxt       = lat_f3;
      lat_off_nxt      = lat_off;
      lat_wdata_nxt    = lat_wdata;
      req_ready_nxt    = 1'b0;
      rsp_valid_nxt    = 1'b0;
      rsp_err_nxt      = 1'b0;
      rsp_rdata_nxt    = rsp_rdata;
      mem_address_nxt  = mem_address;
      mem_data_in_nxt  = mem_data_in;
      mem_w_enable_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            req_ready_nxt = 1'b1;
            if (req_valid && req_ready) begin
               req_ready_nxt = 1'b0;
               lat_f3_nxt    = req_funct3;
               lat_off_nxt   = req_addr[1:0];
               lat_wdata_nxt = req_wdata;
               rsp_rdata_nxt = 32'h0;
               if (req_err_c) begin
                  state_nxt     = S_RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
               end else begin
                  mem_address_nxt = word_addr_c;
                  if (!req_we) begin
                     state_nxt = S_LOAD;
                  end else if (req_funct3 == F3_W) begin
                     state_nxt        = S_WRITE;
                     mem_w_enable_nxt = 1'b1;
                     mem_data_in_nxt  = req_wdata;
                  end else begin
                     state_nxt = S_RMW_RD;
                  end
               end
            end
         end
         S_LOAD: begin
            rsp_rdata_nxt = load_extend(mem_data_out, lat_f3, lat_off);
            rsp_valid_nxt = 1'b1;
            state_nxt     = S_RESP;
         end
         S_RMW_RD: begin
            mem_data_in_nxt  = store_merge(mem_data_out, lat_f3, lat_off, lat_wdata);
            mem_w_enable_nxt = 1'b1;
            state_nxt        = S_WRITE;
         end
         S_WRITE: begin
            rsp_valid_nxt = 1'b1;
            state_nxt     = S_RESP;
         end
         S_RESP: begin
            req_ready_nxt = 1'b1;
            state_nxt     = S_IDLE;
         end
         default: begin
            req_ready_nxt = 1'b1;
            state_nxt     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         lat_f3       <= 3'b000;
         lat_off      <= 2'b00;
         lat_wdata    <= 32'h0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= 32'h0;
         mem_address  <= BASE_ADDR;
         mem_data_in  <= 32'h0;
         mem_w_enable <= 1'b0;
      end else begin
         state        <= state_nxt;
         lat_f3       <= lat_f3_nxt;
         lat_off      <= lat_off_nxt;
         lat_wdata    <= lat_wdata_nxt;
         req_ready    <= req_ready_nxt;
         rsp_valid    <= rsp_valid_nxt;
         rsp_err      <= rsp_err_nxt;
         rsp_rdata    <= rsp_rdata_nxt;
         mem_address  <= mem_address_nxt;
         mem_data_in  <= mem_data_in_nxt;
         mem_w_enable <= mem_w_enable_nxt;
      end
   end

endmodule
